// File: rtl/tlb_fa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tlb_pkg
//  Description : Shared types for the fully associative data TLB: FSM state
//                encoding, per-entry storage record, index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tlb_pkg;

   // Storage width for the VPN/PPN fields of an entry. Each instance writes
   // only its low VPN_W bits and zero-extends, so any VPN_W up to this value
   // is supported by the same record type.
   localparam int TLB_MAX_VPN_W = 64;

   typedef enum logic [0:0] {
      TLB_IDLE = 1'b0,
      TLB_WALK = 1'b1
   } tlb_state_t;

   typedef struct packed {
      logic                     valid;
      logic [TLB_MAX_VPN_W-1:0] vpn;
      logic [TLB_MAX_VPN_W-1:0] ppn;
   } tlb_entry_t;

   // Width of an index into an array of n entries (at least one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_victim_sel.sv
`default_nettype none
// ============================================================================
//  Module      : tlb_victim_sel
//  Description : Fill-victim choice. Lowest-index invalid entry if any,
//                otherwise the round-robin pointer (use_ptr flags that case).
//  Revision    : 1.0 - initial release
// ============================================================================
module tlb_victim_sel
   import tlb_pkg::*;
#(
   parameter int ENTRIES = 4,
   parameter int IDX_W   = idx_width(ENTRIES)
) (
   input  logic [ENTRIES-1:0] valid,
   input  logic [IDX_W-1:0]   victim_ptr,
   output logic [IDX_W-1:0]   victim_idx,
   output logic               use_ptr
);

   // Scan high to low so the lowest invalid index is the one that sticks.
   always_comb begin
      use_ptr    = 1'b1;
      victim_idx = victim_ptr;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            use_ptr    = 1'b0;
            victim_idx = IDX_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/tlb_fa.sv
`default_nettype none
// ============================================================================
//  Module      : tlb_fa
//  Description : Fully associative data TLB. Same-cycle translation on hit;
//                on miss stalls and runs a request/response walk, then fills
//                one entry. Supports a full flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module tlb_fa
   import tlb_pkg::*;
#(
   parameter int ENTRIES   = 4,
   parameter int VA_W      = 32,
   parameter int PAGE_BITS = 10
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req_valid_in,
   input  logic [VA_W-1:0]           virt_addr_in,
   output logic [VA_W-1:0]           phys_addr_out,
   output logic                      hit_out,
   output logic                      stall_out,
   input  logic                      flush_in,
   output logic                      walk_req_valid_out,
   output logic [VA_W-PAGE_BITS-1:0] walk_req_vpn_out,
   input  logic                      walk_resp_valid_in,
   input  logic [VA_W-PAGE_BITS-1:0] walk_resp_ppn_in
);

   localparam int VPN_W = VA_W - PAGE_BITS;
   localparam int IDX_W = idx_width(ENTRIES);

   tlb_state_t          state;
   tlb_state_t          state_next;
   tlb_entry_t          entries [ENTRIES];
   logic [ENTRIES-1:0]  valid_vec;
   logic [IDX_W-1:0]    victim_ptr;
   logic [IDX_W-1:0]    victim_idx;
   logic                use_ptr;
   logic                drop_fill;

   logic [VPN_W-1:0]     req_vpn;
   logic [PAGE_BITS-1:0] req_offset;
   logic                 hit_raw;
   logic [VPN_W-1:0]     hit_ppn;
   logic                 launch;
   logic                 resp_accept;
   logic                 fill_en;

   assign req_vpn    = virt_addr_in[VA_W-1:PAGE_BITS];
   assign req_offset = virt_addr_in[PAGE_BITS-1:0];
   assign fill_en    = resp_accept && !drop_fill;

   // Gather valid bits for the victim selector.
   always_comb begin
      valid_vec = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         valid_vec[i] = entries[i].valid;
      end
   end

   // Associative lookup; scanning downward lets the lowest matching index win.
   always_comb begin
      hit_raw = 1'b0;
      hit_ppn = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (req_valid_in && entries[i].valid &&
             entries[i].vpn == TLB_MAX_VPN_W'(req_vpn)) begin
            hit_raw = 1'b1;
            hit_ppn = entries[i].ppn[VPN_W-1:0];
         end
      end
   end

   // Next-state and control outputs; lookups are suppressed while walking.
   always_comb begin
      state_next         = state;
      hit_out            = 1'b0;
      stall_out          = 1'b0;
      walk_req_valid_out = 1'b0;
      launch             = 1'b0;
      resp_accept        = 1'b0;
      case (state)
         TLB_IDLE: begin
            hit_out   = hit_raw;
            stall_out = req_valid_in && !hit_raw;
            if (req_valid_in && !hit_raw) begin
               launch     = 1'b1;
               state_next = TLB_WALK;
            end
         end
         TLB_WALK: begin
            stall_out          = 1'b1;
            walk_req_valid_out = 1'b1;
            if (walk_resp_valid_in) begin
               resp_accept = 1'b1;
               state_next  = TLB_IDLE;
            end
         end
         default: begin
            state_next = TLB_IDLE;
         end
      endcase
   end

   // Translated address is zero unless the lookup is reported as a hit.
   always_comb begin
      phys_addr_out = '0;
      if (hit_out) begin
         phys_addr_out = {hit_ppn, req_offset};
      end
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= TLB_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Walk VPN latch and drop-fill flag for responses orphaned by a flush.
   always_ff @(posedge clock) begin
      if (reset) begin
         walk_req_vpn_out <= '0;
         drop_fill        <= 1'b0;
      end else begin
         if (launch) begin
            walk_req_vpn_out <= req_vpn;
         end
         if (resp_accept) begin
            drop_fill <= 1'b0;
         end else if (flush_in && (state == TLB_WALK || launch)) begin
            drop_fill <= 1'b1;
         end
      end
   end

   // Entry storage; a flush overrides a same-cycle fill so the entry ends invalid.
   always_ff @(posedge clock) begin
      for (int i = 0; i < ENTRIES; i++) begin
         if (reset) begin
            entries[i].valid <= 1'b0;
         end else begin
            if (fill_en && IDX_W'(i) == victim_idx) begin
               entries[i].vpn   <= TLB_MAX_VPN_W'(walk_req_vpn_out);
               entries[i].ppn   <= TLB_MAX_VPN_W'(walk_resp_ppn_in);
               entries[i].valid <= 1'b1;
            end
            if (flush_in) begin
               entries[i].valid <= 1'b0;
            end
         end
      end
   end

   // Round-robin pointer moves only when a fill actually consumed it.
   always_ff @(posedge clock) begin
      if (reset) begin
         victim_ptr <= '0;
      end else if (fill_en && use_ptr) begin
         if (victim_ptr == IDX_W'(ENTRIES - 1)) begin
            victim_ptr <= '0;
         end else begin
            victim_ptr <= victim_ptr + IDX_W'(1);
         end
      end
   end

   tlb_victim_sel #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W)
   ) u_victim_sel (
      .valid      (valid_vec),
      .victim_ptr (victim_ptr),
      .victim_idx (victim_idx),
      .use_ptr    (use_ptr)
   );

endmodule
`default_nettype wire
